pc_stack: RTL

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack_if.sv | 33 +++
 rtl/pc_stack.sv | 98 +++++++++
 2 files changed

// File: rtl/pc_stack_if.sv
// Control/status bundle for pc_stack: master drives PC actions, slave returns PC and stack state.
// Purely wires, no latency or flow control of its own.
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             write;
  logic             incpc;
  logic             branch;
  logic             call;
  logic             ret;
  logic             read;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_store;
  logic [SPW-1:0]   sp_count;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output write, incpc, branch, call, ret, read, data_in, offset,
    input  data_out, data_store, sp_count, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  write, incpc, branch, call, ret, read, data_in, offset,
    output data_out, data_store, sp_count, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with return-address stack; one action per posedge (ret > call > write > branch > incpc).
// PC/stack update in one cycle, data_out captured on negedge; no backpressure, overflow/underflow set sticky stack_err.
module pc_stack #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 0,
    parameter int STEP      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_stack_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);
  localparam logic [SPW-1:0]   FULL_CNT = SPW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             push;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] ret_addr;
  logic             full, empty;

  assign full     = (sp_q == FULL_CNT);
  assign empty    = (sp_q == '0);
  assign push_idx = AW'(sp_q);
  assign pop_idx  = AW'(sp_q - SPW'(1));
  assign ret_addr = pc_q + STEP_W;

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (bus.ret) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - SPW'(1);
      end
    end else if (bus.call) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        pc_d = bus.data_in;
        sp_d = sp_q + SPW'(1);
      end
    end else if (bus.write) begin
      pc_d = bus.data_in;
    end else if (bus.branch) begin
      pc_d = pc_q + bus.offset;
    end else if (bus.incpc) begin
      pc_d = pc_q + STEP_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_W;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entries at or above sp_q are dead, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_q[push_idx] <= ret_addr;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (bus.read) begin
      dout_q <= pc_q;
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.data_store  = pc_q;
  assign bus.sp_count    = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
endmodule
